// File: rtl/rvs_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state encoding,
// opcodes, datapath mux encodings and the control word. Honours CTRL_ILLEGAL_TRAP_EN.
package rvs_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_LUI,
    S_AUIPC,
    S_ALU_WB,
    S_ADDR,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_PC_INC,
    S_BRANCH,
    S_JALR_ADDR,
    S_JUMP,
    S_TRAP
  } ctrlStateT;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_RD1  = 2'b00;
  localparam logic [1:0] SRCA_ZERO = 2'b01;
  localparam logic [1:0] SRCA_PC   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_ALU    = 2'b10;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       iorD;
    logic       irWrite;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic       pcWrite;
    logic       pcSource;
    logic       regWrite;
    logic [1:0] memtoReg;
    logic       retire;
    logic       illegal;
  } ctrlWordT;

  // DECODE dispatch; unknown opcodes either trap or retire as a NOP.
  function automatic ctrlStateT decodeTarget(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE: decodeTarget = S_ADDR;
      OPC_OP, OPC_OPIMM:   decodeTarget = S_EXEC;
      OPC_BRANCH:          decodeTarget = S_BRANCH;
      OPC_JAL:             decodeTarget = S_JUMP;
      OPC_JALR:            decodeTarget = S_JALR_ADDR;
      OPC_LUI:             decodeTarget = S_LUI;
      OPC_AUIPC:           decodeTarget = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:             decodeTarget = S_TRAP;
`else
      default:             decodeTarget = S_PC_INC;
`endif
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control-word decoder. Moore except IRWrite (MemReady
// in FETCH) and PCWrite/PCSource/Retire (BrTaken in BRANCH). Honours CTRL_ILLEGAL_TRAP_EN.
module ctrl_out_decode
  import rvs_ctrl_pkg::*;
(
  input  ctrlStateT  state_i,
  input  logic [6:0] opcode_i,
  input  logic       brTaken_i,
  input  logic       memReady_i,
  output ctrlWordT   ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.memReq  = 1'b1;
        ctrl_o.irWrite = memReady_i;
      end
      S_DECODE: begin
        ctrl_o.aluSrcA = SRCA_PC;
        ctrl_o.aluSrcB = SRCB_IMM;
      end
      S_EXEC: begin
        ctrl_o.aluSrcB = (opcode_i == OPC_OP) ? SRCB_RD2 : SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_LUI: begin
        ctrl_o.aluSrcA = SRCA_ZERO;
        ctrl_o.aluSrcB = SRCB_IMM;
      end
      S_AUIPC: begin
        ctrl_o.aluSrcA = SRCA_PC;
        ctrl_o.aluSrcB = SRCB_IMM;
      end
      S_ALU_WB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memtoReg = MTR_ALUOUT;
        ctrl_o.aluSrcA  = SRCA_PC;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      S_ADDR, S_JALR_ADDR: begin
        ctrl_o.aluSrcA = SRCA_RD1;
        ctrl_o.aluSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.memReq = 1'b1;
        ctrl_o.iorD   = 1'b1;
      end
      S_LD_WB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memtoReg = MTR_MDR;
        ctrl_o.aluSrcA  = SRCA_PC;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.memReq   = 1'b1;
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      S_PC_INC: begin
        ctrl_o.aluSrcA = SRCA_PC;
        ctrl_o.aluSrcB = SRCB_FOUR;
        ctrl_o.pcWrite = 1'b1;
        ctrl_o.retire  = 1'b1;
      end
      // A taken branch commits the target already latched in ALUOut during DECODE.
      S_BRANCH: begin
        ctrl_o.aluOp    = ALUOP_CMP;
        ctrl_o.pcWrite  = brTaken_i;
        ctrl_o.pcSource = brTaken_i;
        ctrl_o.retire   = brTaken_i;
      end
      S_JUMP: begin
        ctrl_o.aluSrcA  = SRCA_PC;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memtoReg = MTR_ALU;
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = 1'b1;
        ctrl_o.retire   = 1'b1;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: ctrl_o.illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: state register, next-state logic and reset
// gating of the decoded control word. Honours CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl
  import rvs_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic       BrTaken,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] ALUOp,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic       Retire,
  output logic       Illegal
);

  ctrlStateT state_q, state_d;
  ctrlWordT  decWord, outWord;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = decodeTarget(Opcode);
      S_EXEC, S_LUI, S_AUIPC: state_d = S_ALU_WB;
      S_ALU_WB, S_LD_WB, S_PC_INC, S_JUMP: state_d = S_FETCH;
      S_ADDR:      state_d = (Opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:    state_d = MemReady ? S_LD_WB : S_MEM_RD;
      S_MEM_WR:    state_d = MemReady ? S_PC_INC : S_MEM_WR;
      S_BRANCH:    state_d = BrTaken ? S_FETCH : S_PC_INC;
      S_JALR_ADDR: state_d = S_JUMP;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  ctrl_out_decode u_decode (
    .state_i    (state_q),
    .opcode_i   (Opcode),
    .brTaken_i  (BrTaken),
    .memReady_i (MemReady),
    .ctrl_o     (decWord)
  );

  // Outputs are combinational from state, so an in-flight instruction must be
  // silenced explicitly during the reset cycle.
  assign outWord = rst ? '0 : decWord;

  assign MemReq   = outWord.memReq;
  assign MemWrite = outWord.memWrite;
  assign IorD     = outWord.iorD;
  assign IRWrite  = outWord.irWrite;
  assign ALUSrc_A = outWord.aluSrcA;
  assign ALUSrc_B = outWord.aluSrcB;
  assign ALUOp    = outWord.aluOp;
  assign PCWrite  = outWord.pcWrite;
  assign PCSource = outWord.pcSource;
  assign RegWrite = outWord.regWrite;
  assign MemtoReg = outWord.memtoReg;
  assign Retire   = outWord.retire;
  assign Illegal  = outWord.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: constant vector table, hand-written
// corner sequences and randomized instruction streams against a timing model.
module tb_multicycle_ctrl;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] BADOP  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] Opcode = 7'd0;
  logic       BrTaken = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite, Retire, Illegal;
  logic [1:0] ALUSrc_A, ALUSrc_B, ALUOp, MemtoReg;

  int checks = 0;
  int errors = 0;
  int retireAt;
  logic [1:0] aArr[32], bArr[32], opArr[32], mtrArr[32];
  logic       mrArr[32], iodArr[32];

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         cycles;
    logic [1:0] a2;
    logic [1:0] b2;
    logic [1:0] op2;
  } vecT;

  vecT        vecs[$];
  logic [6:0] ops[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .BrTaken(BrTaken), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .ALUSrc_A(ALUSrc_A), .ALUSrc_B(ALUSrc_B), .ALUOp(ALUOp), .PCWrite(PCWrite),
    .PCSource(PCSource), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Retire(Retire),
    .Illegal(Illegal)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus: drive at the falling edge, settle, then sample.
  task automatic applyStimulus(input logic rdy, input logic br, input logic r);
    @(negedge clk);
    MemReady = rdy;
    BrTaken  = br;
    rst      = r;
    #1;
  endtask

  // Leaves the bench just after the rising edge that loads FETCH, with reset released.
  task automatic applyReset();
    @(negedge clk);
    rst      = 1'b1;
    MemReady = 1'($urandom_range(0, 1));
    BrTaken  = 1'b1;
    #1;
    checkOutput("reset outputs",
                32'({MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Retire, Illegal}), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    MemReady = 1'b0;
  endtask

  // Runs one instruction with w1 fetch wait cycles and w2 data wait cycles and checks
  // every cycle against latencies derived from the instruction class.
  task automatic runInstr(input logic [6:0] op, input int w1, input int w2, input logic taken);
    int   base, len, memStart;
    logic isMem, isStore, writes, expSrc, inMem, rdy, last;
    logic [1:0] expMtr;
    logic [5:0] expVec;
    isMem    = (op == LOAD) || (op == STORE);
    isStore  = (op == STORE);
    writes   = (op == OPR) || (op == OPI) || (op == LUI) || (op == AUIPC) ||
               (op == LOAD) || (op == JAL) || (op == JALR);
    expSrc   = ((op == BRANCH) && taken) || (op == JAL) || (op == JALR);
    expMtr   = (op == LOAD) ? 2'b01 : ((op == JAL) || (op == JALR)) ? 2'b10 : 2'b00;
    case (op)
      OPR, OPI, LUI, AUIPC: base = 4;
      LOAD, STORE:          base = 5;
      BRANCH:               base = taken ? 3 : 4;
      JAL:                  base = 3;
      JALR:                 base = 4;
      default:              base = 3;
    endcase
    len      = base + w1 + (isMem ? w2 : 0);
    memStart = w1 + 3;
    retireAt = -1;
    for (int c = 0; c < len; c++) begin
      inMem = isMem && (c >= memStart) && (c <= memStart + w2);
      last  = (c == len - 1);
      if (c < w1)       rdy = 1'b0;
      else if (c == w1) rdy = 1'b1;
      else if (inMem)   rdy = (c == memStart + w2);
      else              rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      Opcode   = op;
      MemReady = rdy;
      BrTaken  = (c == w1 + 2) ? taken : 1'($urandom_range(0, 1));
      #1;
      if (c < 32) begin
        aArr[c] = ALUSrc_A; bArr[c] = ALUSrc_B; opArr[c] = ALUOp;
        mtrArr[c] = MemtoReg; mrArr[c] = MemReq; iodArr[c] = IorD;
      end
      if (Retire && retireAt < 0) retireAt = c;
      expVec = {(c <= w1) || inMem, isStore && inMem, c == w1, last, writes && last, last};
      checkOutput($sformatf("ctrl op=%b c=%0d", op, c),
                  32'({MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Retire}), 32'(expVec));
      if (expVec[5]) checkOutput($sformatf("IorD op=%b c=%0d", op, c), 32'(IorD), 32'(c > w1));
      checkOutput($sformatf("srcA11/Illegal op=%b c=%0d", op, c),
                  32'({ALUSrc_A == 2'b11, Illegal}), 32'd0);
      if (last) begin
        checkOutput($sformatf("PCSource op=%b", op), 32'(PCSource), 32'(expSrc));
        if (writes) checkOutput($sformatf("MemtoReg op=%b", op), 32'(MemtoReg), 32'(expMtr));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    vecs.push_back('{OPR,    1'b0, 4, 2'b00, 2'b00, 2'b10});
    vecs.push_back('{OPI,    1'b0, 4, 2'b00, 2'b01, 2'b10});
    vecs.push_back('{LUI,    1'b0, 4, 2'b01, 2'b01, 2'b00});
    vecs.push_back('{AUIPC,  1'b0, 4, 2'b10, 2'b01, 2'b00});
    vecs.push_back('{LOAD,   1'b0, 5, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{STORE,  1'b0, 5, 2'b00, 2'b01, 2'b00});
    vecs.push_back('{BRANCH, 1'b1, 3, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{BRANCH, 1'b0, 4, 2'b00, 2'b00, 2'b01});
    vecs.push_back('{JAL,    1'b0, 3, 2'b10, 2'b10, 2'b00});
    vecs.push_back('{JALR,   1'b0, 4, 2'b00, 2'b01, 2'b00});
`ifndef CTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{BADOP,  1'b0, 3, 2'b10, 2'b10, 2'b00});
`endif
    ops = '{OPR, OPI, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR};
`ifndef CTRL_ILLEGAL_TRAP_EN
    ops.push_back(BADOP);
    ops.push_back(7'b0001111);
`endif

    applyReset();
    foreach (vecs[i]) begin
      runInstr(vecs[i].op, 0, 0, vecs[i].taken);
      checkOutput($sformatf("latency op=%b br=%0d", vecs[i].op, vecs[i].taken),
                  32'(retireAt + 1), 32'(vecs[i].cycles));
      checkOutput($sformatf("cycle3 selects op=%b", vecs[i].op),
                  32'({aArr[2], bArr[2], opArr[2]}),
                  32'({vecs[i].a2, vecs[i].b2, vecs[i].op2}));
    end

    applyReset();
    runInstr(OPR, 0, 0, 1'b0);
    checkOutput("R-type ALU_WB selects", 32'({aArr[3], bArr[3]}), 32'(4'b1010));

    runInstr(LOAD, 2, 2, 1'b0);
    cnt = 0;
    for (int c = 0; c < 9; c++) cnt += int'(mrArr[c]);
    checkOutput("load 2-wait latency", 32'(retireAt + 1), 32'd9);
    checkOutput("load MemReq cycles", 32'(cnt), 32'd6);
    checkOutput("load IorD in MEM_RD", 32'(iodArr[6]), 32'd1);
    checkOutput("load MemtoReg in LD_WB", 32'(mtrArr[8]), 32'(2'b01));

    applyReset();
    Opcode = STORE;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("MEM_WR request", 32'({MemReq, MemWrite, IorD}), 32'(3'b111));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("reset mid-MEM_WR quiet",
                32'({PCWrite, RegWrite, MemReq, Retire}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("FETCH after reset", 32'({MemReq, IorD, MemWrite}), 32'(3'b100));

`ifdef CTRL_ILLEGAL_TRAP_EN
    applyReset();
    Opcode = BADOP;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("TRAP hold k=%0d", k),
                  32'({Illegal, MemReq, Retire, PCWrite, RegWrite, IRWrite}), 32'(6'b100000));
    end
`endif

    applyReset();
    for (int n = 0; n < 200; n++) begin
      if (n % 50 == 49) applyReset();
      runInstr(ops[$urandom_range(0, ops.size() - 1)], int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle RV32I core. Sequences one shared ALU, one unified memory port and the register file over 3–5 states per instruction. Drives the operand-A mux select (RD1 / zero / PC), the operand-B select, and all datapath write enables. Sits between the instruction register's opcode field and the datapath.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk` — in, 1 — single clock; all state changes on the rising edge.
- `rst` — in, 1 — synchronous, active-high reset.
- `Opcode` — in, 7 — `IR[6:0]`, valid from DECODE onward.
- `BrTaken` — in, 1 — datapath comparator result (funct3-evaluated `RD1`/`RD2`).
- `MemReady` — in, 1 — memory completes the current request this cycle.
- `MemReq` — out, 1 — memory request; held until `MemReady`.
- `MemWrite` — out, 1 — request is a store.
- `IorD` — out, 1 — 0 = address is PC, 1 = address is ALUOut.
- `IRWrite` — out, 1 — latch the instruction from memory data.
- `ALUSrc_A` — out, 2 — 00 = RD1, 01 = zero, 10 = PC; 11 is never driven.
- `ALUSrc_B` — out, 2 — 00 = RD2, 01 = imm, 10 = constant 4.
- `ALUOp` — out, 2 — 00 = add, 01 = compare/branch, 10 = funct-decoded.
- `PCWrite` — out, 1 — PC write enable.
- `PCSource` — out, 1 — 0 = ALU result, 1 = ALUOut.
- `RegWrite` — out, 1 — register-file write enable.
- `MemtoReg` — out, 2 — 00 = ALUOut, 01 = MDR, 10 = ALU result.
- `Retire` — out, 1 — one-cycle pulse in the cycle an instruction commits PC.
- `Illegal` — out, 1 — see Configuration.

## Operation
- ALUOut is latched every cycle. MDR is latched when `MemReady` is high.
- States and their actions (enable outputs not listed are 0; the default selects are `ALUSrc_A`=00, `ALUSrc_B`=00, `ALUOp`=00):
  - FETCH: `MemReq`=1, `IorD`=0. On `MemReady`: `IRWrite`=1, go to DECODE. Otherwise stay.
  - DECODE: A=10, B=01, add, so ALUOut = PC+imm.
    - LOAD/STORE → ADDR
    - OP/OP-IMM → EXEC
    - BRANCH → BRANCH
    - JAL → JUMP
    - JALR → JALR_ADDR
    - LUI → LUI
    - AUIPC → AUIPC
    - other → see Configuration
  - EXEC: A=00, B=00 (OP) or 01 (OP-IMM), `ALUOp`=10 → ALU_WB.
  - LUI: A=01, B=01 → ALU_WB.
  - AUIPC: A=10, B=01 → ALU_WB.
  - ALU_WB: `RegWrite`=1, `MemtoReg`=00. A=10, B=10, `PCWrite`=1, `PCSource`=0, `Retire`=1 → FETCH.
  - ADDR: A=00, B=01, add → MEM_RD (LOAD) or MEM_WR (STORE).
  - MEM_RD: `MemReq`=1, `IorD`=1. Wait for `MemReady` → LD_WB.
  - LD_WB: `RegWrite`=1, `MemtoReg`=01, PC←PC+4 as in ALU_WB, `Retire`=1 → FETCH.
  - MEM_WR: `MemReq`=1, `MemWrite`=1, `IorD`=1. Wait for `MemReady` → PC_INC.
  - PC_INC: A=10, B=10, `PCWrite`=1, `PCSource`=0, `Retire`=1 → FETCH.
  - BRANCH: A=00, B=00, `ALUOp`=01.
    - `BrTaken`=1: `PCWrite`=1, `PCSource`=1, `Retire`=1 → FETCH.
    - `BrTaken`=0: → PC_INC.
  - JALR_ADDR: A=00, B=01, add → JUMP.
  - JUMP: A=10, B=10, `RegWrite`=1, `MemtoReg`=10 (rd←PC+4). `PCWrite`=1, `PCSource`=1, `Retire`=1 → FETCH.
- JALR target LSB clearing is done by the datapath, not by this block.

## Timing
- Outputs are combinational from state (Moore). The exceptions are the `PCWrite`/`Retire` dependence on `BrTaken` in BRANCH and the `IRWrite` dependence on `MemReady` in FETCH (Mealy).
- Cycle counts with zero wait states (each wait cycle adds 1):
  - R/I/LUI/AUIPC: 4
  - load: 5
  - store: 5
  - branch taken: 3
  - branch not taken: 4
  - JAL: 3
  - JALR: 4
- Reset:
  - While `rst`=1, all enables, `MemReq`, `Retire` and `Illegal` are forced to 0, and the state register loads FETCH.
  - The first cycle after reset deassertion is FETCH with `MemReq`=1.
- Reset asserted mid-instruction (including during a memory wait) abandons it. No `PCWrite`/`RegWrite` occurs in the reset cycle.
- `MemReady` outside FETCH/MEM_RD/MEM_WR is ignored.
- `MemReq` stays continuously high across wait cycles. The address selects are stable during the wait.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN`
  - Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds `Illegal`=1 with all enables 0 until reset; `Retire` is never pulsed.
  - Undefined: an unknown opcode goes to PC_INC (executes as NOP, `Retire` pulses). `Illegal` is tied 0.

## Structure
- Package `rvs_ctrl_pkg` holds:
  - the state enum
  - RV32I opcode constants
  - `ALUSrc_A`/`ALUSrc_B`/`ALUOp`/`MemtoReg` encodings (shared with the datapath muxes)
- Sub-module `ctrl_out_decode`: purely combinational state(+`BrTaken`, `MemReady`) → control-word decoder.
- The top level holds the state register and next-state logic.

## Test plan
- **R-type, zero-wait.** Reset, then `Opcode`=0110011, `MemReady`=1 in FETCH → states FETCH, DECODE, EXEC, ALU_WB. `Retire` in cycle 4. In ALU_WB: `RegWrite`=1, `ALUSrc_A`=10, `ALUSrc_B`=10.
- **Load with 2 wait states per access.** `Opcode`=0000011 → `MemReq` high for 3 cycles in both FETCH and MEM_RD. `IorD`=1 in MEM_RD. 9 cycles total. `MemtoReg`=01 in LD_WB.
- **Branch both ways.** `Opcode`=1100011 with `BrTaken`=1 → `PCWrite`=1, `PCSource`=1 in cycle 3. With `BrTaken`=0 → PC_INC in cycle 4, `PCSource`=0.
- **LUI and JAL.** LUI → `ALUSrc_A`=01 in its execute cycle. JAL → in JUMP: `MemtoReg`=10, `RegWrite`=1, `PCSource`=1, 3 cycles total.
- **Reset mid-MEM_WR.** `MemReady`=0, assert `rst` for 1 cycle → no `PCWrite`/`RegWrite`. The next cycle is FETCH with `MemReq`=1.
- **Illegal opcode 1111111.** With `CTRL_ILLEGAL_TRAP_EN`: `Illegal` stays 1 and there is no further `MemReq`. Without it: `Retire` pulses in cycle 3 and fetch resumes.
